// File: rtl/long_to_double_if.sv
// Handshake bus for the integer-to-double converter: operand in, double result out.
interface long_to_double_if;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/long_to_double.sv
// Signed 64-bit integer to IEEE-754 double, round-to-nearest-even,
// normalised by a one-bit-per-cycle shift loop.
module long_to_double (
  input  logic              clk,
  input  logic              rst,
  long_to_double_if.slave   bus
);

  localparam int unsigned DW = 64;
  localparam int unsigned MW = 53;
  localparam int unsigned EW = 12;

  typedef enum logic [2:0] {
    GET_A, CONVERT_0, CONVERT_1, CONVERT_2, ROUND, PACK, PUT_Z
  } state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         a_q, a_d;
  logic [DW-1:0]         value_q, value_d;
  logic [MW-1:0]         z_m_q, z_m_d;
  logic signed [EW-1:0]  z_e_q, z_e_d;
  logic                  z_s_q, z_s_d;
  logic                  guard_q, guard_d;
  logic                  round_q, round_d;
  logic                  sticky_q, sticky_d;
  logic [DW-1:0]         z_q, z_d;
  logic                  ack_q, ack_d;
  logic                  stb_q, stb_d;
  logic [DW-1:0]         out_q, out_d;

  assign bus.input_a_ack  = ack_q;
  assign bus.output_z_stb = stb_q;
  assign bus.output_z     = out_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    value_d  = value_q;
    z_m_d    = z_m_q;
    z_e_d    = z_e_q;
    z_s_d    = z_s_q;
    guard_d  = guard_q;
    round_d  = round_q;
    sticky_d = sticky_q;
    z_d      = z_q;
    ack_d    = ack_q;
    stb_d    = stb_q;
    out_d    = out_q;

    unique case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (ack_q && bus.input_a_stb) begin
          a_d     = bus.input_a;
          ack_d   = 1'b0;
          state_d = CONVERT_0;
        end
      end
      CONVERT_0: begin
        if (a_q == '0) begin
          z_d     = '0;
          state_d = PUT_Z;
        end else begin
          // Negating -2^63 yields 0x8000...0, which is the correct magnitude.
          z_s_d   = a_q[DW-1];
          value_d = a_q[DW-1] ? DW'(-a_q) : a_q;
          z_e_d   = EW'(63);
          state_d = CONVERT_1;
        end
      end
      CONVERT_1: begin
        if (!value_q[DW-1]) begin
          value_d = {value_q[DW-2:0], 1'b0};
          z_e_d   = z_e_q - EW'(1);
        end else begin
          state_d = CONVERT_2;
        end
      end
      CONVERT_2: begin
        z_m_d    = value_q[63:11];
        guard_d  = value_q[10];
        round_d  = value_q[9];
        sticky_d = |value_q[8:0];
        state_d  = ROUND;
      end
      ROUND: begin
        if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + MW'(1);
          // All-ones mantissa wraps to the hidden 1.0 of the next binade.
          if (z_m_q == {MW{1'b1}}) z_e_d = z_e_q + EW'(1);
        end
        state_d = PACK;
      end
      PACK: begin
        z_d[51:0]  = z_m_q[51:0];
        z_d[62:52] = 11'(z_e_q + EW'(1023));
        z_d[63]    = z_s_q;
        state_d    = PUT_Z;
      end
      PUT_Z: begin
        stb_d = 1'b1;
        out_d = z_q;
        if (stb_q && bus.output_z_ack) begin
          stb_d   = 1'b0;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= GET_A;
      a_q      <= '0;
      value_q  <= '0;
      z_m_q    <= '0;
      z_e_q    <= '0;
      z_s_q    <= 1'b0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
      z_q      <= '0;
      ack_q    <= 1'b0;
      stb_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      value_q  <= value_d;
      z_m_q    <= z_m_d;
      z_e_q    <= z_e_d;
      z_s_q    <= z_s_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
      z_q      <= z_d;
      ack_q    <= ack_d;
      stb_q    <= stb_d;
      out_q    <= out_d;
    end
  end

endmodule
